// File: rtl/ptp_tx_tag_tracker.sv
// Issues a sequential PTP tag for each outgoing TX frame before forwarding it, then matches
// the MAC's returned (timestamp, tag) stream against the oldest outstanding tag.
module ptp_tx_tag_tracker #(
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned KEEP_WIDTH      = DATA_WIDTH / 8,
    parameter int unsigned TAG_WIDTH       = 16,
    parameter int unsigned TS_WIDTH        = 96,
    parameter int unsigned MAX_OUTSTANDING = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 65535
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [DATA_WIDTH-1:0]                  s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]                  s_axis_tkeep,
    input  logic                                   s_axis_tvalid,
    output logic                                   s_axis_tready,
    input  logic                                   s_axis_tlast,
    input  logic                                   s_axis_tuser,
    output logic [DATA_WIDTH-1:0]                  m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]                  m_axis_tkeep,
    output logic                                   m_axis_tvalid,
    input  logic                                   m_axis_tready,
    output logic                                   m_axis_tlast,
    output logic                                   m_axis_tuser,
    output logic [TAG_WIDTH-1:0]                   m_axis_tag,
    output logic                                   m_axis_tag_valid,
    input  logic                                   m_axis_tag_ready,
    input  logic [TS_WIDTH-1:0]                    s_axis_ts,
    input  logic [TAG_WIDTH-1:0]                   s_axis_ts_tag,
    input  logic                                   s_axis_ts_valid,
    output logic                                   s_axis_ts_ready,
    output logic [TS_WIDTH-1:0]                    m_axis_ts,
    output logic [TAG_WIDTH-1:0]                   m_axis_ts_tag,
    output logic                                   m_axis_ts_valid,
    input  logic                                   m_axis_ts_ready,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
    output logic [31:0]                            lost_count,
    output logic                                   stale_error,
    output logic                                   timeout_error
);

    localparam int unsigned OUT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned TMR_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TAG  = 2'd1,
        PASS = 2'd2
    } state_t;

    state_t                 r_state;
    logic [TAG_WIDTH-1:0]   r_next_tag;
    logic [TAG_WIDTH-1:0]   r_exp_tag;
    logic [TMR_WIDTH-1:0]   r_timer;

    logic                   w_pass;
    logic                   w_tag_hs;
    logic                   w_ts_hs;
    logic [TAG_WIDTH-1:0]   w_diff;
    logic                   w_match;
    logic                   w_timeout;
    logic [31:0]            w_retired;
    logic [31:0]            w_out_next;
    logic [32:0]            w_lost_sum;

    // Frame pass-through is only opened once the frame's tag has been accepted.
    assign w_pass        = (r_state == PASS);
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tkeep  = s_axis_tkeep;
    assign m_axis_tlast  = s_axis_tlast;
    assign m_axis_tuser  = s_axis_tuser;
    assign m_axis_tvalid = w_pass && s_axis_tvalid;
    assign s_axis_tready = w_pass && m_axis_tready;

    assign w_tag_hs        = (r_state == TAG) && m_axis_tag_ready;
    assign s_axis_ts_ready = !m_axis_ts_valid || m_axis_ts_ready;
    assign w_ts_hs         = s_axis_ts_valid && s_axis_ts_ready;

    // Distance of the returned tag from the oldest outstanding one; anything inside the
    // outstanding window is a match that retires every older tag as lost.
    assign w_diff    = s_axis_ts_tag - r_exp_tag;
    assign w_match   = w_ts_hs && (32'(w_diff) < 32'(outstanding));
    assign w_timeout = (TIMEOUT_CYCLES != 0) && !w_ts_hs && (outstanding != '0)
                       && (r_timer == TMR_WIDTH'(TIMEOUT_CYCLES - 1));

    assign w_retired  = w_match ? (32'(w_diff) + 32'd1) : 32'(w_timeout);
    assign w_out_next = 32'(outstanding) + 32'(w_tag_hs) - w_retired;
    assign w_lost_sum = {1'b0, lost_count} + (w_match ? 33'(w_diff) : 33'(w_timeout));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= IDLE;
            r_next_tag       <= '0;
            m_axis_tag       <= '0;
            m_axis_tag_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (s_axis_tvalid && (32'(outstanding) < MAX_OUTSTANDING)) begin
                        m_axis_tag       <= r_next_tag;
                        m_axis_tag_valid <= 1'b1;
                        r_state          <= TAG;
                    end
                end
                TAG: begin
                    if (m_axis_tag_ready) begin
                        m_axis_tag_valid <= 1'b0;
                        r_next_tag       <= r_next_tag + TAG_WIDTH'(1);
                        r_state          <= PASS;
                    end
                end
                PASS: begin
                    if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Return matching, timeout retirement and bookkeeping, all from pre-cycle values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axis_ts       <= '0;
            m_axis_ts_tag   <= '0;
            m_axis_ts_valid <= 1'b0;
            r_exp_tag       <= '0;
            r_timer         <= '0;
            outstanding     <= '0;
            lost_count      <= '0;
            stale_error     <= 1'b0;
            timeout_error   <= 1'b0;
        end else begin
            stale_error   <= w_ts_hs && !w_match;
            timeout_error <= w_timeout;
            outstanding   <= OUT_WIDTH'(w_out_next);
            lost_count    <= w_lost_sum[32] ? 32'hFFFF_FFFF : w_lost_sum[31:0];

            if (w_match) begin
                m_axis_ts       <= s_axis_ts;
                m_axis_ts_tag   <= s_axis_ts_tag;
                m_axis_ts_valid <= 1'b1;
                r_exp_tag       <= s_axis_ts_tag + TAG_WIDTH'(1);
            end else begin
                if (m_axis_ts_ready) begin
                    m_axis_ts_valid <= 1'b0;
                end
                if (w_timeout) begin
                    r_exp_tag <= r_exp_tag + TAG_WIDTH'(1);
                end
            end

            if (w_match || w_timeout || (outstanding == '0)) begin
                r_timer <= '0;
            end else if (!w_ts_hs) begin
                r_timer <= r_timer + TMR_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_ptp_tx_tag_tracker.sv
// Bench for ptp_tx_tag_tracker: directed scenarios plus a randomized run checked each cycle
// against a queue-of-outstanding-tags reference model.
module tb_ptp_tx_tag_tracker;

    localparam int unsigned DW   = 64;
    localparam int unsigned KW   = DW / 8;
    localparam int unsigned TW   = 8;
    localparam int unsigned SW   = 96;
    localparam int unsigned MAXO = 4;
    localparam int unsigned TMO  = 100;
    localparam int unsigned OW   = $clog2(MAXO + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_axis_tdata, m_axis_tdata;
    logic [KW-1:0] s_axis_tkeep, m_axis_tkeep;
    logic          s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser;
    logic          m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
    logic [TW-1:0] m_axis_tag;
    logic          m_axis_tag_valid, m_axis_tag_ready;
    logic [SW-1:0] s_axis_ts, m_axis_ts;
    logic [TW-1:0] s_axis_ts_tag, m_axis_ts_tag;
    logic          s_axis_ts_valid, s_axis_ts_ready, m_axis_ts_valid, m_axis_ts_ready;
    logic [OW-1:0] outstanding;
    logic [31:0]   lost_count;
    logic          stale_error, timeout_error;

    int checks   = 0;
    int failures = 0;
    bit rnd_done = 1'b0;

    // Reference model state
    int            m_ph;
    logic [TW-1:0] m_next;
    logic [TW-1:0] mq[$];
    int            age;
    longint        lostm;
    bit            e_tag_valid, e_ts_valid, e_stale, e_timeout;
    logic [TW-1:0] e_tag, e_ts_tag;
    logic [SW-1:0] e_ts;

    ptp_tx_tag_tracker #(
        .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .TAG_WIDTH(TW), .TS_WIDTH(SW),
        .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .m_axis_tag(m_axis_tag), .m_axis_tag_valid(m_axis_tag_valid), .m_axis_tag_ready(m_axis_tag_ready),
        .s_axis_ts(s_axis_ts), .s_axis_ts_tag(s_axis_ts_tag), .s_axis_ts_valid(s_axis_ts_valid),
        .s_axis_ts_ready(s_axis_ts_ready),
        .m_axis_ts(m_axis_ts), .m_axis_ts_tag(m_axis_ts_tag), .m_axis_ts_valid(m_axis_ts_valid),
        .m_axis_ts_ready(m_axis_ts_ready),
        .outstanding(outstanding), .lost_count(lost_count),
        .stale_error(stale_error), .timeout_error(timeout_error)
    );

    always #5 clk = ~clk;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: outstanding tags kept as a FIFO of tag values; a return retires every
    // entry up to and including its own tag, anything not found in the FIFO is stale.
    initial begin
        int  pre_n;
        int  hit;
        bit  ts_hs;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_ph = 0; m_next = '0; mq.delete(); age = 0; lostm = 0;
                e_tag_valid = 0; e_tag = '0; e_ts_valid = 0; e_ts = '0; e_ts_tag = '0;
                e_stale = 0; e_timeout = 0;
            end else begin
                pre_n = mq.size();
                ts_hs = s_axis_ts_valid && (!e_ts_valid || m_axis_ts_ready);
                e_stale = 0;
                e_timeout = 0;
                if (m_axis_ts_ready) e_ts_valid = 0;
                if (ts_hs) begin
                    hit = -1;
                    for (int i = 0; i < pre_n; i++) if (mq[i] == s_axis_ts_tag) hit = i;
                    if (hit >= 0) begin
                        e_ts_valid = 1; e_ts = s_axis_ts; e_ts_tag = s_axis_ts_tag;
                        lostm = lostm + hit;
                        if (lostm > 64'hFFFF_FFFF) lostm = 64'hFFFF_FFFF;
                        repeat (hit + 1) void'(mq.pop_front());
                        age = 0;
                    end else begin
                        e_stale = 1;
                    end
                end else if (pre_n > 0 && age == int'(TMO) - 1) begin
                    void'(mq.pop_front());
                    lostm = lostm + 1;
                    if (lostm > 64'hFFFF_FFFF) lostm = 64'hFFFF_FFFF;
                    e_timeout = 1;
                    age = 0;
                end else if (pre_n > 0) begin
                    age = age + 1;
                end
                if (pre_n == 0) age = 0;
                case (m_ph)
                    0: if (s_axis_tvalid && pre_n < int'(MAXO)) begin
                        m_ph = 1; e_tag_valid = 1; e_tag = m_next;
                    end
                    1: if (m_axis_tag_ready) begin
                        e_tag_valid = 0; mq.push_back(e_tag); m_next = TW'(m_next + 1); m_ph = 2;
                    end
                    default: if (s_axis_tvalid && m_axis_tready && s_axis_tlast) m_ph = 0;
                endcase
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = 0; s_axis_tlast = 0; s_axis_tuser = 0;
        m_axis_tready = 1; m_axis_tag_ready = 0;
        s_axis_ts = '0; s_axis_ts_tag = '0; s_axis_ts_valid = 0; m_axis_ts_ready = 1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send_frame(input int n, input bit rnd);
        int b = 0;
        int guard = 0;
        bit hs;
        while (b < n && guard < 2000) begin
            s_axis_tvalid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_axis_tdata  = {$urandom, $urandom};
            s_axis_tkeep  = KW'($urandom);
            s_axis_tuser  = 1'($urandom);
            s_axis_tlast  = (b == n - 1);
            if (rnd) begin
                m_axis_tready    = ($urandom_range(0, 3) != 0);
                m_axis_tag_ready = ($urandom_range(0, 2) != 0);
            end
            @(negedge clk);
            hs = s_axis_tvalid && s_axis_tready;
            @(posedge clk); #1;
            if (hs) b++;
            guard++;
        end
        s_axis_tvalid = 0;
        s_axis_tlast  = 0;
        if (guard >= 2000) begin
            checks++; failures++;
            $display("FAIL frame_timeout: sent %0d of %0d beats", b, n);
        end
    endtask

    task automatic send_return(input logic [TW-1:0] tag, input logic [SW-1:0] ts);
        int guard = 0;
        bit hs = 0;
        s_axis_ts_valid = 1; s_axis_ts_tag = tag; s_axis_ts = ts;
        while (!hs && guard < 500) begin
            @(negedge clk);
            hs = s_axis_ts_ready;
            @(posedge clk); #1;
            guard++;
        end
        s_axis_ts_valid = 0;
        if (!hs) begin
            checks++; failures++;
            $display("FAIL return_timeout: ts_ready never seen for tag %0h", tag);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (m_axis_tag_valid !== 0 || m_axis_ts_valid !== 0 || outstanding !== 0 || lost_count !== 0
            || stale_error !== 0 || timeout_error !== 0 || s_axis_tready !== 0 || m_axis_tvalid !== 0) begin
            failures++;
            $display("FAIL reset: tagv=%0b tsv=%0b out=%0d lost=%0d stale=%0b tmo=%0b sready=%0b mvalid=%0b (want all 0)",
                     m_axis_tag_valid, m_axis_ts_valid, outstanding, lost_count, stale_error,
                     timeout_error, s_axis_tready, m_axis_tvalid);
        end
    endtask

    task automatic test_single_frame();
        logic [DW-1:0] d;
        do_reset();
        m_axis_tag_ready = 1;
        d = {$urandom, $urandom};
        s_axis_tvalid = 1; s_axis_tdata = d; s_axis_tlast = 0;
        @(negedge clk);
        checks++;
        if (m_axis_tvalid !== 0 || m_axis_tag_valid !== 0) begin
            failures++;
            $display("FAIL single_idle: mvalid=%0b tagv=%0b (want 0,0)", m_axis_tvalid, m_axis_tag_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (m_axis_tag_valid !== 1 || m_axis_tag !== 0 || m_axis_tvalid !== 0) begin
            failures++;
            $display("FAIL single_tag: tagv=%0b tag=%0h mvalid=%0b (want 1,0,0)", m_axis_tag_valid, m_axis_tag, m_axis_tvalid);
        end
        @(posedge clk); #1;
        checks++;
        if (m_axis_tvalid !== 1 || m_axis_tdata !== d || outstanding !== 1) begin
            failures++;
            $display("FAIL single_fwd: mvalid=%0b data=%0h out=%0d (want 1,%0h,1)", m_axis_tvalid, m_axis_tdata, outstanding, d);
        end
        for (int b = 1; b < 8; b++) begin
            @(posedge clk); #1;
            s_axis_tdata = {$urandom, $urandom};
            s_axis_tlast = (b == 7);
        end
        @(posedge clk); #1;
        s_axis_tvalid = 0; s_axis_tlast = 0;
        checks++;
        if (s_axis_tready !== 0 || m_axis_tag_valid !== 0) begin
            failures++;
            $display("FAIL single_end: sready=%0b tagv=%0b (want 0,0)", s_axis_tready, m_axis_tag_valid);
        end
        send_return(8'h00, 96'h1234);
        checks++;
        if (m_axis_ts_valid !== 1 || m_axis_ts !== 96'h1234 || m_axis_ts_tag !== 0 || outstanding !== 0 || lost_count !== 0) begin
            failures++;
            $display("FAIL single_ret: tsv=%0b ts=%0h tag=%0h out=%0d lost=%0d (want 1,1234,0,0,0)",
                     m_axis_ts_valid, m_axis_ts, m_axis_ts_tag, outstanding, lost_count);
        end
    endtask

    task automatic test_skip();
        do_reset();
        m_axis_tag_ready = 1;
        repeat (3) send_frame(2, 1'b0);
        checks++;
        if (outstanding !== 3) begin
            failures++;
            $display("FAIL skip_out: out=%0d (want 3)", outstanding);
        end
        send_return(8'h02, 96'hABCD);
        checks++;
        if (m_axis_ts_valid !== 1 || m_axis_ts_tag !== 8'h02 || m_axis_ts !== 96'hABCD || lost_count !== 2 || outstanding !== 0) begin
            failures++;
            $display("FAIL skip_ret: tsv=%0b tag=%0h ts=%0h lost=%0d out=%0d (want 1,2,abcd,2,0)",
                     m_axis_ts_valid, m_axis_ts_tag, m_axis_ts, lost_count, outstanding);
        end
    endtask

    task automatic test_full();
        bit done = 0;
        do_reset();
        m_axis_tag_ready = 1;
        repeat (4) send_frame(1, 1'b0);
        s_axis_tvalid = 1; s_axis_tlast = 1; s_axis_tdata = {$urandom, $urandom};
        repeat (10) begin @(posedge clk); #1; end
        checks++;
        if (s_axis_tready !== 0 || m_axis_tag_valid !== 0 || outstanding !== 4) begin
            failures++;
            $display("FAIL full_stall: sready=%0b tagv=%0b out=%0d (want 0,0,4)", s_axis_tready, m_axis_tag_valid, outstanding);
        end
        send_return(8'h00, 96'h5);
        @(posedge clk); #1;
        checks++;
        if (m_axis_tag_valid !== 1 || m_axis_tag !== 8'h04 || outstanding !== 3) begin
            failures++;
            $display("FAIL full_resume: tagv=%0b tag=%0h out=%0d (want 1,4,3)", m_axis_tag_valid, m_axis_tag, outstanding);
        end
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge clk);
            done = s_axis_tready;
            @(posedge clk); #1;
        end
        s_axis_tvalid = 0; s_axis_tlast = 0;
        checks++;
        if (!done || outstanding !== 4) begin
            failures++;
            $display("FAIL full_finish: beat_sent=%0b out=%0d (want 1,4)", done, outstanding);
        end
    endtask

    task automatic test_stale();
        do_reset();
        send_return(8'h07, 96'h77);
        checks++;
        if (stale_error !== 1 || m_axis_ts_valid !== 0 || outstanding !== 0) begin
            failures++;
            $display("FAIL stale_empty: stale=%0b tsv=%0b out=%0d (want 1,0,0)", stale_error, m_axis_ts_valid, outstanding);
        end
        @(posedge clk); #1;
        checks++;
        if (stale_error !== 0) begin
            failures++;
            $display("FAIL stale_pulse: stale=%0b one cycle later (want 0)", stale_error);
        end
        m_axis_tag_ready = 1;
        send_frame(1, 1'b0);
        send_return(8'h00, 96'h10);
        checks++;
        if (m_axis_ts_valid !== 1 || stale_error !== 0) begin
            failures++;
            $display("FAIL stale_first: tsv=%0b stale=%0b (want 1,0)", m_axis_ts_valid, stale_error);
        end
        send_return(8'h00, 96'h11);
        checks++;
        if (stale_error !== 1 || m_axis_ts_valid !== 0 || lost_count !== 0 || outstanding !== 0) begin
            failures++;
            $display("FAIL stale_dup: stale=%0b tsv=%0b lost=%0d out=%0d (want 1,0,0,0)",
                     stale_error, m_axis_ts_valid, lost_count, outstanding);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        bit seen = 0;
        do_reset();
        m_axis_tag_ready = 1;
        s_axis_tvalid = 1; s_axis_tlast = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        while (!seen && n < 300) begin
            @(posedge clk); #1;
            s_axis_tvalid = 0; s_axis_tlast = 0;
            n++;
            seen = timeout_error;
        end
        checks++;
        if (!seen || n != int'(TMO) || lost_count !== 1 || outstanding !== 0) begin
            failures++;
            $display("FAIL timeout: seen=%0b cycles=%0d lost=%0d out=%0d (want 1,%0d,1,0)",
                     seen, n, lost_count, outstanding, TMO);
        end
        @(posedge clk); #1;
        checks++;
        if (timeout_error !== 0) begin
            failures++;
            $display("FAIL timeout_pulse: tmo=%0b one cycle later (want 0)", timeout_error);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        m_axis_tag_ready = 1;
        for (int i = 0; i < 255; i++) begin
            send_frame(1, 1'b0);
            send_return(TW'(i), SW'(i));
        end
        send_frame(1, 1'b0);
        send_frame(1, 1'b0);
        checks++;
        if (outstanding !== 2 || lost_count !== 0) begin
            failures++;
            $display("FAIL wrap_issue: out=%0d lost=%0d (want 2,0)", outstanding, lost_count);
        end
        send_return(8'hFF, 96'hF0);
        checks++;
        if (m_axis_ts_valid !== 1 || m_axis_ts_tag !== 8'hFF || outstanding !== 1 || lost_count !== 0) begin
            failures++;
            $display("FAIL wrap_ff: tsv=%0b tag=%0h out=%0d lost=%0d (want 1,ff,1,0)",
                     m_axis_ts_valid, m_axis_ts_tag, outstanding, lost_count);
        end
        send_return(8'h00, 96'hF1);
        checks++;
        if (m_axis_ts_valid !== 1 || m_axis_ts_tag !== 8'h00 || m_axis_ts !== 96'hF1 || outstanding !== 0 || lost_count !== 0) begin
            failures++;
            $display("FAIL wrap_00: tsv=%0b tag=%0h ts=%0h out=%0d lost=%0d (want 1,0,f1,0,0)",
                     m_axis_ts_valid, m_axis_ts_tag, m_axis_ts, outstanding, lost_count);
        end
    endtask

    task automatic test_reset_mid_pass();
        do_reset();
        m_axis_tag_ready = 1;
        send_frame(1, 1'b0);
        send_frame(1, 1'b0);
        s_axis_tvalid = 1; s_axis_tlast = 0;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (m_axis_tag_valid !== 0 || outstanding !== 0 || lost_count !== 0 || s_axis_tready !== 0
            || m_axis_tvalid !== 0 || m_axis_ts_valid !== 0) begin
            failures++;
            $display("FAIL reset_mid: tagv=%0b out=%0d lost=%0d sready=%0b mvalid=%0b tsv=%0b (want all 0)",
                     m_axis_tag_valid, outstanding, lost_count, s_axis_tready, m_axis_tvalid, m_axis_ts_valid);
        end
        s_axis_tvalid = 0;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        s_axis_tvalid = 1; s_axis_tlast = 1;
        @(posedge clk); #1;
        checks++;
        if (m_axis_tag_valid !== 1 || m_axis_tag !== 0) begin
            failures++;
            $display("FAIL reset_tag: tagv=%0b tag=%0h (want 1,0)", m_axis_tag_valid, m_axis_tag);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        s_axis_tvalid = 0; s_axis_tlast = 0;
    endtask

    task automatic test_random();
        do_reset();
        rnd_done = 0;
        fork
            begin
                for (int f = 0; f < 60; f++) begin
                    send_frame($urandom_range(1, 4), 1'b1);
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                end
                rnd_done = 1;
            end
            begin
                logic [TW-1:0] t;
                int r;
                while (!rnd_done) begin
                    repeat ($urandom_range(0, 40)) begin @(posedge clk); #1; end
                    r = $urandom_range(0, 99);
                    if (mq.size() > 0 && r < 70) t = mq[0];
                    else if (mq.size() > 0 && r < 85) t = mq[$urandom_range(0, mq.size() - 1)];
                    else t = TW'($urandom);
                    send_return(t, {$urandom, $urandom, $urandom});
                end
            end
            begin
                int cyc = 0;
                bit bad;
                while (!rnd_done) begin
                    @(posedge clk);
                    #2 m_axis_ts_ready = ($urandom_range(0, 3) != 0);
                    @(negedge clk);
                    cyc++;
                    checks++;
                    if (m_axis_tag_valid !== e_tag_valid || (e_tag_valid && m_axis_tag !== e_tag)) begin
                        failures++;
                        $display("FAIL rnd_tag cyc=%0d: tagv=%0b tag=%0h (want %0b,%0h)", cyc, m_axis_tag_valid, m_axis_tag, e_tag_valid, e_tag);
                    end
                    checks++;
                    if (m_axis_ts_valid !== e_ts_valid || (e_ts_valid && (m_axis_ts !== e_ts || m_axis_ts_tag !== e_ts_tag))) begin
                        failures++;
                        $display("FAIL rnd_ts cyc=%0d: tsv=%0b ts=%0h tag=%0h (want %0b,%0h,%0h)", cyc, m_axis_ts_valid, m_axis_ts, m_axis_ts_tag, e_ts_valid, e_ts, e_ts_tag);
                    end
                    checks++;
                    if (outstanding !== OW'(mq.size()) || lost_count !== 32'(lostm) || stale_error !== e_stale || timeout_error !== e_timeout) begin
                        failures++;
                        $display("FAIL rnd_cnt cyc=%0d: out=%0d lost=%0d stale=%0b tmo=%0b (want %0d,%0d,%0b,%0b)", cyc, outstanding, lost_count, stale_error, timeout_error, mq.size(), lostm, e_stale, e_timeout);
                    end
                    if (m_ph == 2)
                        bad = (m_axis_tvalid !== s_axis_tvalid) || (s_axis_tready !== m_axis_tready)
                              || (m_axis_tdata !== s_axis_tdata) || (m_axis_tlast !== s_axis_tlast);
                    else
                        bad = (m_axis_tvalid !== 1'b0) || (s_axis_tready !== 1'b0);
                    bad = bad || (s_axis_ts_ready !== (!e_ts_valid || m_axis_ts_ready));
                    checks++;
                    if (bad) begin
                        failures++;
                        $display("FAIL rnd_path cyc=%0d: phase=%0d mvalid=%0b sready=%0b tsready=%0b", cyc, m_ph, m_axis_tvalid, s_axis_tready, s_axis_ts_ready);
                    end
                end
            end
        join
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_single_frame();
        test_skip();
        test_full();
        test_stale();
        test_timeout();
        test_wrap();
        test_reset_mid_pass();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ptp_tx_tag_tracker.md
Name: ptp_tx_tag_tracker

Overview:
- Sits directly upstream of the 10G MAC/PHY FIFO with PTP, in the logic clock domain.
- Gates each outgoing TX frame so that it is issued a unique sequential PTP tag on the MAC's TX timestamp-tag input before the frame's first beat is forwarded.
- Consumes the MAC's returned (timestamp, tag) stream and matches each return against the oldest outstanding tag.
- Re-emits matched timestamps, and counts lost, stale and timed-out tags.

Parameters:
- DATA_WIDTH, 64, AXI stream data width.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- TAG_WIDTH, 16, PTP tag width; tag counter wraps modulo 2^TAG_WIDTH.
- TS_WIDTH, 96, timestamp width.
- MAX_OUTSTANDING, 16, maximum issued-but-unreturned tags (1..2^TAG_WIDTH-1).
- TIMEOUT_CYCLES, 65535, cycles the oldest outstanding tag may wait before being retired as lost (0 disables timeout).

Ports:
- clk  in  1  block clock (logic_clk domain).
- rst  in  1  asynchronous active-high reset.
- s_axis_tdata/tkeep/tvalid/tready/tlast/tuser  in/in/in/out/in/in  DATA_WIDTH/KEEP_WIDTH/1/1/1/1  frames from host.
- m_axis_tdata/tkeep/tvalid/tready/tlast/tuser  out/out/out/in/out/out  same widths  frames to MAC tx_axis.
- m_axis_tag  out  TAG_WIDTH  tag to MAC.
- m_axis_tag_valid  out  1  tag valid.
- m_axis_tag_ready  in  1  tag accepted.
- s_axis_ts  in  TS_WIDTH  returned timestamp.
- s_axis_ts_tag  in  TAG_WIDTH  returned tag.
- s_axis_ts_valid  in  1  returned timestamp valid.
- s_axis_ts_ready  out  1  returned timestamp accepted.
- m_axis_ts  out  TS_WIDTH  matched timestamp.
- m_axis_ts_tag  out  TAG_WIDTH  matched tag.
- m_axis_ts_valid  out  1  matched timestamp valid.
- m_axis_ts_ready  in  1  downstream accepts timestamp.
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  issued-minus-retired count.
- lost_count  out  32  saturating count of tags skipped or timed out.
- stale_error  out  1  one-cycle pulse when a return is discarded as out-of-window.
- timeout_error  out  1  one-cycle pulse when the oldest tag is retired by timeout.

Behaviour:
- Reset:
  - All valid outputs 0; state IDLE; next_tag=0; exp_tag=0; outstanding=0; lost_count=0; timer=0; error pulses 0.
  - Reset mid-frame abandons the frame; the host must restart it.
- Frame FSM, IDLE:
  - s_axis_tready=0, m_axis_tvalid=0.
  - When s_axis_tvalid=1 and outstanding<MAX_OUTSTANDING: register m_axis_tag=next_tag, m_axis_tag_valid=1, go to TAG.
  - If outstanding=MAX_OUTSTANDING, wait in IDLE.
- Frame FSM, TAG:
  - Hold m_axis_tag stable and tag_valid high until m_axis_tag_ready.
  - On handshake: tag_valid=0, next_tag+=1 (wraps), outstanding+=1, go to PASS.
- Frame FSM, PASS:
  - Combinational pass-through: m_axis_*=s_axis_*, s_axis_tready=m_axis_tready.
  - A tvalid&tready&tlast beat returns the FSM to IDLE on the next cycle.
  - A single-beat frame is legal.
- Minimum overhead per frame: 2 cycles between the first beat arriving and its forwarding.
- Return path, output register:
  - s_axis_ts_ready = !m_axis_ts_valid || m_axis_ts_ready.
  - On return handshake, compute diff = (s_axis_ts_tag - exp_tag) mod 2^TAG_WIDTH.
- diff < outstanding (match or later):
  - Register m_axis_ts/tag, m_axis_ts_valid=1.
  - exp_tag = s_axis_ts_tag+1; outstanding -= diff+1; lost_count += diff (saturating at 2^32-1); timer=0.
- diff >= outstanding (stale, duplicate, or nothing outstanding):
  - Discard; stale_error=1 for one cycle; no counter change.
- Timeout:
  - Timer increments while outstanding>0 and no return handshake occurs; it is cleared when outstanding=0.
  - When timer reaches TIMEOUT_CYCLES: exp_tag+=1, outstanding-=1, lost_count+=1, timeout_error=1, timer=0.
  - A return handshake in the same cycle takes priority and suppresses the timeout.
- Simultaneous events: a tag issue and a retire in the same cycle combine, with outstanding changed by +1-(retired count). All updates are computed from pre-cycle values.
- m_axis_ts_valid is cleared on m_axis_ts_ready unless refilled in the same cycle.

Test Plan:
- Single 64-byte frame, tag ready held high → m_axis_tag=0 issued before first beat; outstanding=1; return (ts=0x1234, tag=0) → m_axis_ts=0x1234, tag 0, outstanding=0, lost_count=0.
- 3 frames issue tags 0,1,2; return only tag 2 → emitted with tag 2, lost_count=2, outstanding=0.
- MAX_OUTSTANDING=4: 5 frames with no returns → 5th frame stalls in IDLE with s_axis_tready=0 until one return arrives, then it receives tag 4.
- Return with tag 7 while outstanding=0 → stale_error pulses, nothing emitted; duplicate return of an already-matched tag → stale_error.
- TIMEOUT_CYCLES=100, one frame with no return → timeout_error at cycle 100 after issue, lost_count=1, outstanding=0.
- next_tag preset near wrap (issue 65535 frames): tags 0xFFFF then 0x0000 returned in order → both matched, lost_count unchanged; assert rst mid-PASS → all outputs cleared, next_tag=0.
